// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers scan position from hsync/vsync, measures line and
// frame timing against nominal parameters and reports lock.
module vga_timing_rx #(
  parameter int unsigned W           = 1280,
  parameter int unsigned HFP         = 48,
  parameter int unsigned HSP         = 112,
  parameter int unsigned HBP         = 248,
  parameter int unsigned H           = 1024,
  parameter int unsigned VFP         = 1,
  parameter int unsigned VSP         = 3,
  parameter int unsigned VBP         = 38,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                                        pxclk,
  input  logic                                        rst_n,
  input  logic                                        hsync,
  input  logic                                        vsync,
  output logic                                        locked,
  output logic                                        inframe,
  output logic [$clog2(W)-1:0]                        scanx,
  output logic [$clog2(H)-1:0]                        scany,
  output logic [$clog2(2*(W+HFP+HSP+HBP))-1:0]        line_len,
  output logic [$clog2(2*(H+VFP+VSP+VBP))-1:0]        frame_lines,
  output logic                                        timing_err
);

  localparam int unsigned TW = W + HFP + HSP + HBP;
  localparam int unsigned TH = H + VFP + VSP + VBP;
  localparam int unsigned HW = $clog2(2*TW);
  localparam int unsigned VW = $clog2(2*TH);
  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);
  localparam int unsigned GW = $clog2(LOCK_FRAMES+1);

  localparam logic [HW-1:0] HMAX  = HW'(2*TW-1);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [HW-1:0] TW_L  = HW'(TW);
  localparam logic [HW-1:0] HSP_L = HW'(HSP);
  localparam logic [HW-1:0] X0    = HW'(HSP+HBP);
  localparam logic [HW-1:0] X1    = HW'(HSP+HBP+W);
  localparam logic [VW-1:0] VMAX  = VW'(2*TH-1);
  localparam logic [VW-1:0] V_ONE = VW'(1);
  localparam logic [VW-1:0] TH_L  = VW'(TH);
  localparam logic [VW-1:0] Y0    = VW'(VSP+VBP-1);
  localparam logic [VW-1:0] Y1    = VW'(VSP+VBP-1+H);
  localparam logic [GW-1:0] GMAX  = GW'(LOCK_FRAMES);
  localparam logic [GW-1:0] G_ONE = GW'(1);

  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;
  logic [HW-1:0] hswid_q, hswid_d;
  logic          vs_pend_q, vs_pend_d;
  logic          aligned_q, aligned_d;
  logic          frame_bad_q, frame_bad_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [HW-1:0] line_len_q, line_len_d;
  logic [VW-1:0] frame_lines_q, frame_lines_d;
  logic          timing_err_q, timing_err_d;

  logic          hs_rise, hs_fall, vs_rise, frame_end;
  logic [HW-1:0] hpos_inc;
  logic [VW-1:0] vpos_inc;
  logic          err_tmo, err_wid, err_line, err_frame, err_other, err_any;

  // Edge detection, counters, timing checks and lock accounting.
  always_comb begin
    hs_d          = hsync;
    vs_d          = vsync;
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    hswid_d       = hswid_q;
    vs_pend_d     = vs_pend_q;
    aligned_d     = aligned_q;
    frame_bad_d   = frame_bad_q;
    good_cnt_d    = good_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    err_tmo       = 1'b0;
    err_wid       = 1'b0;
    err_line      = 1'b0;
    err_frame     = 1'b0;

    hs_rise   = hsync & ~hs_q;
    hs_fall   = ~hsync & hs_q;
    vs_rise   = vsync & ~vs_q;
    frame_end = hs_rise & vs_pend_q;
    hpos_inc  = hpos_q + H_ONE;
    vpos_inc  = vpos_q + V_ONE;

    // Horizontal position; reaching saturation is a missing-hsync timeout.
    if (hs_rise) begin
      line_len_d = hpos_inc;
      hpos_d     = '0;
      if (aligned_q && (hpos_inc != TW_L)) err_line = 1'b1;
    end else if (hpos_q != HMAX) begin
      hpos_d = hpos_inc;
      if (hpos_inc == HMAX) err_tmo = 1'b1;
    end

    // Pulse width is only graded for pulses whose rising edge was seen
    // (hswid == 0 means no pulse in progress).
    if (hs_rise) begin
      hswid_d = H_ONE;
    end else if (hs_fall) begin
      if ((hswid_q != '0) && (hswid_q != HSP_L)) err_wid = 1'b1;
      hswid_d = '0;
    end else if (hsync && (hswid_q != '0) && (hswid_q != HMAX)) begin
      hswid_d = hswid_q + H_ONE;
    end

    // A vsync rise on the same edge as the closing hsync rise stays pending.
    if (hs_rise) begin
      if (vs_pend_q) begin
        frame_lines_d = vpos_inc;
        vpos_d        = '0;
      end else if (vpos_q != VMAX) begin
        vpos_d = vpos_inc;
      end
    end
    if (frame_end) vs_pend_d = 1'b0;
    if (vs_rise)   vs_pend_d = 1'b1;

    err_other = err_tmo | err_wid | err_line;

    // Frame grading at the vsync-aligned hsync rise; first one only aligns.
    if (frame_end) begin
      frame_bad_d = 1'b0;
      if (!aligned_q) begin
        aligned_d = 1'b1;
      end else if (frame_bad_q || err_other || (vpos_inc != TH_L)) begin
        err_frame = 1'b1;
      end else if (good_cnt_q != GMAX) begin
        good_cnt_d = good_cnt_q + G_ONE;
      end
    end else if (err_other) begin
      frame_bad_d = 1'b1;
    end

    err_any      = err_other | err_frame;
    timing_err_d = err_any;
    if (err_any) good_cnt_d = '0;
  end

  // State registers.
  always_ff @(posedge pxclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hpos_q        <= HMAX;
      vpos_q        <= '0;
      hswid_q       <= '0;
      vs_pend_q     <= 1'b0;
      aligned_q     <= 1'b0;
      frame_bad_q   <= 1'b0;
      good_cnt_q    <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      timing_err_q  <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hswid_q       <= hswid_d;
      vs_pend_q     <= vs_pend_d;
      aligned_q     <= aligned_d;
      frame_bad_q   <= frame_bad_d;
      good_cnt_q    <= good_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      timing_err_q  <= timing_err_d;
    end
  end

  // Lock status and recovered coordinates.
  always_comb begin
    locked  = (good_cnt_q == GMAX);
    inframe = locked && (hpos_q >= X0) && (hpos_q < X1) &&
              (vpos_q >= Y0) && (vpos_q < Y1);
    scanx   = '0;
    scany   = '0;
    if (inframe) begin
      scanx = XW'(hpos_q - X0);
      scany = YW'(vpos_q - Y0);
    end
  end

  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: drives vga_timing_rx from a behavioural sync generator
// with injectable faults and checks lock, timing and coordinates.
module tb_vga_timing_rx;

  localparam int W = 16, HFP = 2, HSP = 3, HBP = 4;
  localparam int H = 8, VFP = 1, VSP = 2, VBP = 3;
  localparam int TW = W + HFP + HSP + HBP;
  localparam int TH = H + VFP + VSP + VBP;
  localparam int BUDGET = 4 * TW * TH;

  logic       pxclk = 1'b0;
  logic       rst_n, hsync, vsync;
  logic       locked, inframe, timing_err;
  logic [3:0] scanx;
  logic [2:0] scany;
  logic [5:0] line_len;
  logic [4:0] frame_lines;

  int ncmp = 0, nfail = 0, err_cnt = 0;
  int gh, gv, len_cur, wid_cur, cg_h, cg_v;
  int ln_line = -1, ln_len = 0, wd_line = -1, wd_wid = 0;
  bit chk_coord = 1'b0;
  logic [15:0] xseen = '0;
  logic [7:0]  yseen = '0;

  vga_timing_rx #(
    .W(W), .HFP(HFP), .HSP(HSP), .HBP(HBP),
    .H(H), .VFP(VFP), .VSP(VSP), .VBP(VBP), .LOCK_FRAMES(2)
  ) dut (
    .pxclk(pxclk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .locked(locked), .inframe(inframe), .scanx(scanx), .scany(scany),
    .line_len(line_len), .frame_lines(frame_lines), .timing_err(timing_err)
  );

  always #5 pxclk = ~pxclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit gen_active(input int h, input int v);
    return (h >= HSP+HBP) && (h < HSP+HBP+W) && (v >= VSP+VBP) && (v < VSP+VBP+H);
  endfunction

  task automatic drive();
    hsync = (gh < wid_cur);
    vsync = (gv < VSP);
  endtask

  task automatic gen_advance();
    gh++;
    if (gh >= len_cur) begin
      gh = 0;
      gv = (gv + 1) % TH;
      len_cur = TW;
      wid_cur = HSP;
      if (gv == ln_line) begin len_cur = ln_len;  ln_line = -1; end
      if (gv == wd_line) begin wid_cur = wd_wid;  wd_line = -1; end
    end
  endtask

  // One pixel clock: DUT consumes the generator position (cg_h, cg_v), and
  // its outputs must show the generator's view of that same position.
  task automatic step();
    bit act;
    @(posedge pxclk);
    #1;
    cg_h = gh;
    cg_v = gv;
    if (timing_err === 1'b1) err_cnt++;
    if (chk_coord) begin
      act = gen_active(cg_h, cg_v);
      chk("inframe", inframe, act);
      chk("scanx", scanx, act ? cg_h - (HSP+HBP) : 0);
      chk("scany", scany, act ? cg_v - (VSP+VBP) : 0);
      if (act) begin
        xseen[cg_h - (HSP+HBP)] = 1'b1;
        yseen[cg_v - (VSP+VBP)] = 1'b1;
      end
    end
    gen_advance();
    drive();
  endtask

  task automatic run_to(input int v, input int h);
    bit hit = 1'b0;
    for (int i = 0; i < BUDGET && !hit; i++) begin
      step();
      if (cg_v == v && cg_h == h) hit = 1'b1;
    end
    if (!hit) begin
      ncmp++;
      nfail++;
      $error("FAIL run_to_timeout observed=none expected=%0d,%0d", v, h);
    end
  endtask

  // After a fault: the faulted frame grades bad, then two good frames lock.
  task automatic relock(input string tag);
    run_to(1, 0);
    chk({tag, "_grade_bad_err"}, timing_err, 1);
    chk({tag, "_grade_bad_lock"}, locked, 0);
    run_to(1, 0);
    chk({tag, "_good1_lock"}, locked, 0);
    chk({tag, "_good1_err"}, timing_err, 0);
    run_to(1, 0);
    chk({tag, "_good2_lock"}, locked, 1);
    chk({tag, "_good2_err"}, timing_err, 0);
  endtask

  initial begin
    int fl, hx;

    // Reset with generator parked at (0,0): syncs already high.
    rst_n = 1'b0;
    gh = 0; gv = 0; len_cur = TW; wid_cur = HSP;
    drive();
    repeat (3) @(posedge pxclk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_inframe", inframe, 0);
    chk("rst_scanx", scanx, 0);
    chk("rst_scany", scany, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_frame_lines", frame_lines, 0);
    chk("rst_timing_err", timing_err, 0);
    #3 rst_n = 1'b1;

    // Nominal acquisition.
    run_to(1, 0);
    chk("first_hs_line_len", line_len, 2*TW);
    run_to(2, 0);
    chk("second_hs_line_len", line_len, TW);
    run_to(1, 0);
    chk("align_locked", locked, 0);
    run_to(1, 0);
    chk("grade1_frame_lines", frame_lines, TH);
    chk("grade1_locked", locked, 0);
    run_to(0, TW-1);
    chk("pre_lock_locked", locked, 0);
    run_to(1, 0);
    chk("lock_locked", locked, 1);
    chk("lock_frame_lines", frame_lines, TH);
    chk("nominal_err_cnt", err_cnt, 0);

    // Coordinate tracking for two full frames.
    chk_coord = 1'b1;
    repeat (2*TW*TH) step();
    chk_coord = 1'b0;
    chk("x_cover", xseen, 16'hFFFF);
    chk("y_cover", yseen, 8'hFF);
    chk("track_err_cnt", err_cnt, 0);
    chk("track_locked", locked, 1);

    // Stretched line.
    fl = $urandom_range(TH-1, 2);
    run_to(1, 5);
    ln_line = fl; ln_len = TW + 1;
    run_to(fl, TW);
    chk("len_pre_locked", locked, 1);
    chk("len_pre_err", timing_err, 0);
    step();
    chk("len_err", timing_err, 1);
    chk("len_locked", locked, 0);
    chk("len_line_len", line_len, TW + 1);
    step();
    chk("len_err_pulse", timing_err, 0);
    relock("len");

    // Wide hsync pulse.
    fl = $urandom_range(TH-1, 2);
    run_to(1, 5);
    wd_line = fl; wd_wid = HSP + 1;
    run_to(fl, HSP);
    chk("wid_pre_err", timing_err, 0);
    chk("wid_pre_locked", locked, 1);
    step();
    chk("wid_err", timing_err, 1);
    chk("wid_locked", locked, 0);
    relock("wid");

    // Missing hsync: 60 low cycles saturates the position counter.
    fl = $urandom_range(TH-1, 2);
    run_to(1, 5);
    ln_line = fl; ln_len = HSP + 60;
    run_to(fl, 2*TW-2);
    chk("tmo_pre_err", timing_err, 0);
    chk("tmo_pre_locked", locked, 1);
    step();
    chk("tmo_err", timing_err, 1);
    chk("tmo_locked", locked, 0);
    err_cnt = 0;
    run_to(fl, HSP + 59);
    chk("tmo_single_pulse", err_cnt, 0);
    chk("tmo_inframe", inframe, 0);
    chk("tmo_scanx", scanx, 0);
    chk("tmo_scany", scany, 0);
    step();
    chk("tmo_sat_line_len", line_len, 2*TW);
    relock("tmo");

    // Asynchronous reset mid-frame at recovered row 3.
    hx = $urandom_range(HSP+HBP+13, HSP+HBP+3);
    run_to(VSP+VBP+3, hx);
    chk("pre_rst_inframe", inframe, 1);
    chk("pre_rst_scany", scany, 3);
    chk("pre_rst_scanx", scanx, hx - (HSP+HBP));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_inframe", inframe, 0);
    chk("mid_rst_scanx", scanx, 0);
    chk("mid_rst_scany", scany, 0);
    chk("mid_rst_line_len", line_len, 0);
    chk("mid_rst_frame_lines", frame_lines, 0);
    chk("mid_rst_timing_err", timing_err, 0);
    repeat (3) step();
    chk("held_rst_locked", locked, 0);
    #3 rst_n = 1'b1;
    err_cnt = 0;
    run_to(1, 0);
    chk("rerst_align_locked", locked, 0);
    chk("rerst_align_err_cnt", err_cnt, 0);
    run_to(1, 0);
    chk("rerst_good1_locked", locked, 0);
    chk("rerst_good1_frame_lines", frame_lines, TH);
    run_to(1, 0);
    chk("rerst_relock", locked, 1);
    chk("rerst_err_cnt", err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
